rr_mux_arbiter: RTL and testbench

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

---
 rtl/rr_mux_arb_pkg.sv | 16 +
 rtl/rr_mux_arbiter_mux_n.sv | 24 ++
 rtl/rr_mux_arbiter.sv | 104 ++++++++++
 tb/tb_rr_mux_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
//   state_t : output register occupancy (EMPTY / FULL)
//   idx_w() : bit width of a requester index for a given requester count
package rr_mux_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Index width, never below one bit so single-bit selects stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux_n.sv
// N:1 payload multiplexer with binary select.
//   sel  : binary index of the selected input
//   din  : N packed payload words
//   dout : selected word (zero if sel is out of range)
module mux_n #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = 2
) (
  input  logic [SW-1:0]       sel,
  input  logic [N-1:0][W-1:0] din,
  output logic [W-1:0]        dout
);

  // Compare-and-select form keeps non-power-of-two N free of
  // out-of-range indexing.
  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i)) dout = din[i];
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 arbiter feeding a single registered output word.
//   clk, rst_n : clock, synchronous active-low reset
//   req_valid  : per-requester valid
//   req_data   : per-requester payload
//   req_ready  : per-requester accept (one-hot of the winner or zero)
//   out_valid  : output register holds a word
//   out_data   : registered payload of the winner
//   out_ready  : downstream accept
//   grant_id   : index of the requester whose word sits in out_data
// Build option RR_MUX_ARB_FIXED_PRIO_EN: lowest-index valid requester
// always wins and the rotating pointer is removed.
module rr_mux_arbiter
  import rr_mux_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        out_ready,
  output logic [idx_w(N_REQ)-1:0]     grant_id
);

  localparam int IW = idx_w(N_REQ);

  state_t            state;
  logic              load_en;
  logic              load;
  logic              found;
  logic [IW-1:0]     winner;
  logic [N_REQ-1:0]  onehot;
  logic [WIDTH-1:0]  sel_data;

`ifndef RR_MUX_ARB_FIXED_PRIO_EN
  logic [IW-1:0]     ptr;
`endif

  // The register can take a word when empty or when it drains this cycle.
  // rst_n gates acceptance so nothing is handshaken while in reset.
  assign load_en = rst_n & ((state == EMPTY) | out_ready);
  assign load    = load_en & found;

  // Winner search: first valid requester starting at ptr, wrapping.
  always_comb begin
    int j;
    found  = 1'b0;
    winner = '0;
    onehot = '0;
    j      = 0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef RR_MUX_ARB_FIXED_PRIO_EN
      j = k;
`else
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
`endif
      if (!found && req_valid[j]) begin
        found     = 1'b1;
        winner    = IW'(j);
        onehot[j] = 1'b1;
      end
    end
  end

  assign req_ready = onehot & {N_REQ{load_en}};
  assign out_valid = (state == FULL);

  mux_n #(
    .N  (N_REQ),
    .W  (WIDTH),
    .SW (IW)
  ) u_mux (
    .sel  (winner),
    .din  (req_data),
    .dout (sel_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      grant_id <= '0;
`ifndef RR_MUX_ARB_FIXED_PRIO_EN
      ptr      <= '0;
`endif
    end else if (load) begin
      state    <= FULL;
      out_data <= sel_data;
      grant_id <= winner;
`ifndef RR_MUX_ARB_FIXED_PRIO_EN
      ptr      <= (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;
`endif
    end else if ((state == FULL) && out_ready) begin
      // Drained with nothing to refill: payload and id keep last values.
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter (N_REQ=4, WIDTH=8).
// A reference model predicts req_ready each cycle and pushes expected
// output words into a scoreboard queue on every accepted request; words
// are popped and compared when the output transfers. Scenario tasks add
// direct checks on grant order observed from the handshakes.
module tb_rr_mux_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    logic [1:0]   gid;
    logic [W-1:0] data;
  } sb_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0][W-1:0] req_data;
  logic [N-1:0]      req_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic              out_ready;
  logic [1:0]        grant_id;

  int total = 0;
  int bad   = 0;

  sb_t sb[$];
  int  glog[$];

  bit           m_known = 1'b0;
  bit           m_full  = 1'b0;
  int           m_ptr   = 0;
  logic [1:0]   last_gid  = '0;
  logic [W-1:0] last_data = '0;

  rr_mux_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
`ifdef RR_MUX_ARB_FIXED_PRIO_EN
      j = k;
`else
      j = (p + k) % N;
`endif
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // One clock: check at negedge, advance the model after posedge.
  task automatic step();
    int           w;
    bit           le;
    logic [N-1:0] er;
    sb_t          e;
    @(negedge clk);
    le = rst_n && (!m_full || out_ready);
    w  = pick(req_valid, m_ptr);
    er = '0;
    if (le && w >= 0) er[w] = 1'b1;
    total++;
    if (req_ready !== er) begin
      bad++;
      $display("FAIL req_ready got=%b exp=%b t=%0t", req_ready, er, $time);
    end
    if (m_known) begin
      total++;
      if (out_valid !== m_full) begin
        bad++;
        $display("FAIL out_valid got=%b exp=%b t=%0t", out_valid, m_full, $time);
      end
      if (m_full) begin
        total++;
        if (out_data !== sb[0].data || grant_id !== sb[0].gid) begin
          bad++;
          $display("FAIL out_word got=%h/%0d exp=%h/%0d t=%0t",
                   out_data, grant_id, sb[0].data, sb[0].gid, $time);
        end
      end else begin
        total++;
        if (out_data !== last_data || grant_id !== last_gid) begin
          bad++;
          $display("FAIL held_word got=%h/%0d exp=%h/%0d t=%0t",
                   out_data, grant_id, last_data, last_gid, $time);
        end
      end
    end
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) glog.push_back(i);
    if (le && w >= 0) begin
      e.gid  = 2'(w);
      e.data = req_data[w];
    end
    @(posedge clk);
    if (!rst_n) begin
      m_known   = 1'b1;
      m_full    = 1'b0;
      m_ptr     = 0;
      last_gid  = '0;
      last_data = '0;
      sb.delete();
    end else begin
      if (m_full && out_ready) begin
        last_gid  = sb[0].gid;
        last_data = sb[0].data;
        void'(sb.pop_front());
      end
      if (le && w >= 0) begin
        sb.push_back(e);
        m_full = 1'b1;
        m_ptr  = (w + 1) % N;
      end else if (m_full && out_ready) begin
        m_full = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = '1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) req_data[i] = W'(8'h50 + i);
    rst_n = 1'b0;
    step();
    step();
    total++;
    if (req_ready !== 4'b0000 || out_valid !== 1'b0 || grant_id !== 2'd0) begin
      bad++;
      $display("FAIL reset got rdy=%b ov=%b gid=%0d exp 0000/0/0",
               req_ready, out_valid, grant_id);
    end
    rst_n = 1'b1;
  endtask

  task automatic check_glog(input string name, input int exp[], input int n);
    total++;
    if (glog.size() != n) begin
      bad++;
      $display("FAIL %s count got=%0d exp=%0d", name, glog.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        total++;
        if (glog[i] != exp[i]) begin
          bad++;
          $display("FAIL %s grant[%0d] got=%0d exp=%0d", name, i, glog[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_all_valid();
    int exp[] = '{0, 1, 2, 3, 0};
    do_reset();
    glog.delete();
    req_valid = 4'b1111;
    out_ready = 1'b1;
    repeat (5) step();
    check_glog("all_valid", exp, 5);
  endtask

  task automatic test_sparse();
    int exp[] = '{1, 3, 1, 3};
    do_reset();
    glog.delete();
    req_valid = 4'b1010;
    out_ready = 1'b1;
    repeat (4) step();
    check_glog("sparse", exp, 4);
  endtask

  task automatic test_backpressure();
    int exp[] = '{3};
    do_reset();
    req_valid   = 4'b0100;
    req_data[2] = 8'hA5;
    out_ready   = 1'b0;
    step();
    req_valid = 4'b1111;
    req_data[2] = 8'h5A;
    repeat (5) begin
      step();
      total++;
      if (out_data !== 8'hA5 || grant_id !== 2'd2 || req_ready !== 4'b0000) begin
        bad++;
        $display("FAIL backpressure got=%h/%0d rdy=%b exp=a5/2 rdy=0000",
                 out_data, grant_id, req_ready);
      end
    end
    glog.delete();
    out_ready = 1'b1;
    step();
    check_glog("bp_next", exp, 1);
  endtask

  task automatic test_reset_full();
    int exp[] = '{0};
    do_reset();
    req_valid = 4'b1111;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_full out_valid got=%b exp=0", out_valid);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    glog.delete();
    step();
    check_glog("reset_full", exp, 1);
  endtask

  task automatic test_drain();
    do_reset();
    req_valid   = 4'b1000;
    req_data[3] = 8'h3C;
    out_ready   = 1'b1;
    step();
    req_valid = 4'b0000;
    step();
    step();
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h3C || grant_id !== 2'd3) begin
      bad++;
      $display("FAIL drain got ov=%b %h/%0d exp 0 3c/3", out_valid, out_data, grant_id);
    end
  endtask

  task automatic test_fixed_prio();
    int exp[] = '{1, 1, 1, 1, 1, 1};
    do_reset();
    glog.delete();
    req_valid = 4'b0110;
    out_ready = 1'b1;
    repeat (6) step();
    check_glog("fixed_prio", exp, 6);
  endtask

  task automatic test_random();
    do_reset();
    repeat (300) begin
      req_valid = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) req_data[i] = 8'($urandom);
      step();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    #1;
    test_reset();
`ifdef RR_MUX_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_all_valid();
    test_sparse();
    test_backpressure();
    test_reset_full();
`endif
    test_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
